// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and frame-state encoding for the serial control line.
package ctrl_pkg;
    localparam logic [7:0] FRAME_HEAD = 8'h5A;
    localparam logic [7:0] BCAST_ID   = 8'hFF;
    localparam int         FRAME_LEN  = 6;

    typedef enum logic [$clog2(FRAME_LEN)-1:0] {
        S_HEAD, S_DEV, S_MOD, S_ADDR, S_DATA, S_SUM
    } frame_state_t;
endpackage

// File: rtl/ctrl_byte_rx.sv
// ctrl_byte_rx: 8N1 byte receiver with a 2-FF input synchroniser and mid-bit sampling.
module ctrl_byte_rx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_ctrl,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       frm_err,
    output logic       line_idle
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          sync1, rx, armed;

    assign line_idle = (st == IDLE);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b1;
            rx        <= 1'b1;
            armed     <= 1'b1;
            st        <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            sync1    <= rx_ctrl;
            rx       <= sync1;
            byte_vld <= 1'b0;
            frm_err  <= 1'b0;
            case (st)
                // armed tracks the previous line level, so a start needs a high-to-low edge
                IDLE: begin
                    armed <= rx;
                    if (armed && !rx) begin
                        st  <= START;
                        cnt <= CW'(CLK_PER_BIT / 2 - 1);
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        st      <= rx ? IDLE : DATA;
                        cnt     <= CW'(CLK_PER_BIT - 1);
                        bit_idx <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == '0) begin
                        shift   <= {rx, shift[7:1]};
                        cnt     <= CW'(CLK_PER_BIT - 1);
                        bit_idx <= bit_idx + 1'b1;
                        st      <= (bit_idx == 3'd7) ? STOP : DATA;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == '0) begin
                        st        <= IDLE;
                        armed     <= rx;
                        byte_vld  <= rx;
                        frm_err   <= !rx;
                        byte_data <= rx ? shift : byte_data;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/ctrl_frame_rx.sv
// ctrl_frame_rx: parses 6-byte checksummed command frames from the serial control
// line and presents validated fields with a one-cycle cmd_vld pulse.
module ctrl_frame_rx
    import ctrl_pkg::*;
#(
    parameter int         CLK_PER_BIT = 100,
    parameter int         GAP_TIMEOUT = 2000,
    parameter logic [7:0] MY_DEV_ID   = 8'h01
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_ctrl,
    output logic [7:0] dev_id,
    output logic [7:0] mod_id,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       cmd_vld,
    output logic       dev_hit,
    output logic       err_pulse
);
    localparam int GW = $clog2(GAP_TIMEOUT + 1);

    frame_state_t st;
    logic [7:0]   byte_data, sh_dev, sh_mod, sh_addr, sh_data;
    logic         byte_vld, frm_err, line_idle, sum_ok, gap_run, gap_hit;
    logic [GW-1:0] gap;

    ctrl_byte_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_byte (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .rx_ctrl  (rx_ctrl),
        .byte_data(byte_data),
        .byte_vld (byte_vld),
        .frm_err  (frm_err),
        .line_idle(line_idle)
    );

    assign sum_ok  = (byte_data == (sh_dev ^ sh_mod ^ sh_addr ^ sh_data));
    assign gap_run = (st != S_HEAD) && line_idle;
    assign gap_hit = gap_run && (gap == GW'(GAP_TIMEOUT - 1));

    // a completing byte takes priority over a coincident gap timeout
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            st        <= S_HEAD;
            gap       <= '0;
            sh_dev    <= '0;
            sh_mod    <= '0;
            sh_addr   <= '0;
            sh_data   <= '0;
            dev_id    <= '0;
            mod_id    <= '0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            dev_hit   <= 1'b0;
            cmd_vld   <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            cmd_vld   <= 1'b0;
            err_pulse <= 1'b0;
            if (frm_err) begin
                st        <= S_HEAD;
                gap       <= '0;
                err_pulse <= 1'b1;
            end else if (byte_vld) begin
                gap <= '0;
                case (st)
                    S_HEAD: st <= (byte_data == FRAME_HEAD) ? S_DEV : S_HEAD;
                    S_DEV: begin
                        sh_dev <= byte_data;
                        st     <= S_MOD;
                    end
                    S_MOD: begin
                        sh_mod <= byte_data;
                        st     <= S_ADDR;
                    end
                    S_ADDR: begin
                        sh_addr <= byte_data;
                        st      <= S_DATA;
                    end
                    S_DATA: begin
                        sh_data <= byte_data;
                        st      <= S_SUM;
                    end
                    S_SUM: begin
                        if (sum_ok) begin
                            dev_id   <= sh_dev;
                            mod_id   <= sh_mod;
                            cmd_addr <= sh_addr;
                            cmd_data <= sh_data;
                            dev_hit  <= (sh_dev == MY_DEV_ID) || (sh_dev == BCAST_ID);
                            cmd_vld  <= 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                        st <= S_HEAD;
                    end
                    default: st <= S_HEAD;
                endcase
            end else if (gap_hit) begin
                st        <= S_HEAD;
                gap       <= '0;
                err_pulse <= 1'b1;
            end else if (gap_run) begin
                gap <= gap + 1'b1;
            end else if (st == S_HEAD) begin
                gap <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ctrl_frame_rx.sv
// tb_ctrl_frame_rx: serial-line stimulus with a scoreboard of expected command frames.
`timescale 1ns/1ps
module tb_ctrl_frame_rx;
    import ctrl_pkg::*;

    localparam int CPB = 42;
    localparam int GAP = 2000;

    typedef struct packed {
        logic [7:0] dev;
        logic [7:0] mod;
        logic [7:0] addr;
        logic [7:0] data;
        logic       hit;
    } frm_t;

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ctrl = 1'b1;
    logic [7:0] dev_id, mod_id, cmd_addr, cmd_data;
    logic       cmd_vld, dev_hit, err_pulse;

    frm_t exp_q[$];
    int   checks = 0, passes = 0;
    int   err_cnt = 0, byte_cnt = 0, cmd_cnt = 0;
    logic bv_prev = 1'b0;

    ctrl_frame_rx #(.CLK_PER_BIT(CPB), .GAP_TIMEOUT(GAP), .MY_DEV_ID(8'h01)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .rx_ctrl  (rx_ctrl),
        .dev_id   (dev_id),
        .mod_id   (mod_id),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .cmd_vld  (cmd_vld),
        .dev_hit  (dev_hit),
        .err_pulse(err_pulse)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        frm_t got, e;
        if (err_pulse) err_cnt++;
        if (dut.byte_vld) byte_cnt++;
        if (cmd_vld) begin
            cmd_cnt++;
            got = {dev_id, mod_id, cmd_addr, cmd_data, dev_hit};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_cmd_vld got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL frame_fields got=%h required=%h", got, e);
                else passes++;
            end
            checks++;
            if (bv_prev !== 1'b1) $display("FAIL cmd_latency byte_vld_prev=%b required=1", bv_prev);
            else passes++;
        end
        bv_prev = dut.byte_vld;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        rx_ctrl = b;
        repeat (CPB) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_ok);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a, input logic [7:0] x);
        exp_q.push_back({d, m, a, x, (d == 8'h01) || (d == 8'hFF)});
        send_byte(FRAME_HEAD);
        send_byte(d);
        send_byte(m);
        send_byte(a);
        send_byte(x);
        send_byte(d ^ m ^ a ^ x);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk_sys);
        checks++;
        if ({dev_id, mod_id, cmd_addr, cmd_data} !== 32'h0) $display("FAIL reset_fields got=%h required=0", {dev_id, mod_id, cmd_addr, cmd_data});
        else passes++;
        checks++;
        if ({cmd_vld, dev_hit, err_pulse} !== 3'b000) $display("FAIL reset_flags got=%b required=000", {cmd_vld, dev_hit, err_pulse});
        else passes++;
        rst = 1'b0;
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic test_valid();
        int e0 = err_cnt;
        send_frame(8'h01, 8'h02, 8'h10, 8'hAB);
        drain();
        checks++;
        if (exp_q.size() != 0) begin $display("FAIL valid_missing pending=%0d required=0", exp_q.size()); exp_q.delete(); end
        else passes++;
        checks++;
        if (err_cnt - e0 != 0) $display("FAIL valid_err got=%0d required=0", err_cnt - e0);
        else passes++;
        checks++;
        if ({dev_id, mod_id, cmd_addr, cmd_data, dev_hit} !== {32'h010210AB, 1'b1}) $display("FAIL valid_hold got=%h required=%h", {dev_id, mod_id, cmd_addr, cmd_data, dev_hit}, {32'h010210AB, 1'b1});
        else passes++;
    endtask

    task automatic test_bcast_miss();
        int c0 = cmd_cnt;
        send_frame(8'hFF, 8'h03, 8'h20, 8'h55);
        send_frame(8'h07, 8'h04, 8'h30, 8'h66);
        drain();
        checks++;
        if (cmd_cnt - c0 != 2 || exp_q.size() != 0) begin $display("FAIL bcast_miss_count got=%0d required=2", cmd_cnt - c0); exp_q.delete(); end
        else passes++;
        checks++;
        if ({dev_id, dev_hit} !== {8'h07, 1'b0}) $display("FAIL miss_hold got=%h required=%h", {dev_id, dev_hit}, {8'h07, 1'b0});
        else passes++;
    endtask

    task automatic test_bad_sum();
        int e0 = err_cnt;
        int c0 = cmd_cnt;
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'hAB); send_byte(8'h00);
        repeat (20) @(negedge clk_sys);
        checks++;
        if (err_cnt - e0 != 1 || cmd_cnt != c0) $display("FAIL bad_sum errs=%0d cmds=%0d required=1,0", err_cnt - e0, cmd_cnt - c0);
        else passes++;
        checks++;
        if ({dev_id, mod_id, cmd_addr, cmd_data, dev_hit} !== {32'h07043066, 1'b0}) $display("FAIL bad_sum_hold got=%h required=%h", {dev_id, mod_id, cmd_addr, cmd_data, dev_hit}, {32'h07043066, 1'b0});
        else passes++;
        send_frame(8'h01, 8'h02, 8'h10, 8'hAB);
        drain();
        checks++;
        if (exp_q.size() != 0 || cmd_cnt - c0 != 1) begin $display("FAIL after_bad_sum cmds=%0d required=1", cmd_cnt - c0); exp_q.delete(); end
        else passes++;
    endtask

    task automatic test_framing();
        int e0 = err_cnt;
        int c0 = cmd_cnt;
        send_byte(8'h5A);
        send_byte(8'h01);
        send_byte(8'h02, 1'b0);
        send_bit(1'b1);
        send_byte(8'h10); send_byte(8'hAB); send_byte(8'hB8);
        repeat (100) @(negedge clk_sys);
        checks++;
        if (err_cnt - e0 != 1) $display("FAIL framing_err got=%0d required=1", err_cnt - e0);
        else passes++;
        checks++;
        if (cmd_cnt != c0) $display("FAIL framing_dropped cmds=%0d required=0", cmd_cnt - c0);
        else passes++;
    endtask

    task automatic test_glitch();
        int e0 = err_cnt;
        int b0 = byte_cnt;
        rx_ctrl = 1'b0;
        repeat (20) @(negedge clk_sys);
        rx_ctrl = 1'b1;
        repeat (200) @(negedge clk_sys);
        checks++;
        if (byte_cnt != b0 || err_cnt != e0) $display("FAIL glitch bytes=%0d errs=%0d required=0,0", byte_cnt - b0, err_cnt - e0);
        else passes++;
    endtask

    task automatic test_gap();
        int e0 = err_cnt;
        int at = -1;
        send_byte(8'h5A); send_byte(8'h01); send_byte(8'h02);
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk_sys);
            if (err_pulse && at < 0) at = i;
        end
        checks++;
        if (err_cnt - e0 != 1) $display("FAIL gap_err_count got=%0d required=1", err_cnt - e0);
        else passes++;
        checks++;
        if (at < GAP - CPB || at > GAP + 4) $display("FAIL gap_timing got=%0d required=%0d..%0d", at, GAP - CPB, GAP + 4);
        else passes++;
        send_frame(8'h01, 8'h05, 8'h06, 8'h07);
        drain();
        checks++;
        if (exp_q.size() != 0 || err_cnt - e0 != 1) begin $display("FAIL after_gap pending=%0d errs=%0d required=0,1", exp_q.size(), err_cnt - e0); exp_q.delete(); end
        else passes++;
    endtask

    task automatic test_back_to_back();
        int e0 = err_cnt;
        int c0 = cmd_cnt;
        logic [7:0] d, m, a, x;
        for (int i = 0; i < 16; i++) begin
            d = (i % 3 == 0) ? 8'h01 : (i % 5 == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 255));
            a = 8'($urandom_range(0, 255));
            x = 8'($urandom_range(0, 255));
            send_frame(d, m, a, x);
        end
        drain();
        checks++;
        if (cmd_cnt - c0 != 16 || exp_q.size() != 0) begin $display("FAIL b2b_count got=%0d required=16", cmd_cnt - c0); exp_q.delete(); end
        else passes++;
        checks++;
        if (err_cnt != e0) $display("FAIL b2b_err got=%0d required=0", err_cnt - e0);
        else passes++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) send_frame(8'h01, 8'(i), 8'h40, 8'h99);
        send_byte(8'h5A);
        send_byte(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (CPB / 3) @(negedge clk_sys);
        rst = 1'b1;
        rx_ctrl = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({dev_id, mod_id, cmd_addr, cmd_data, cmd_vld, dev_hit, err_pulse} !== 35'h0) $display("FAIL reset_mid got=%h required=0", {dev_id, mod_id, cmd_addr, cmd_data, cmd_vld, dev_hit, err_pulse});
        else passes++;
        checks++;
        if (exp_q.size() != 0) begin $display("FAIL reset_mid_pending got=%0d required=0", exp_q.size()); exp_q.delete(); end
        else passes++;
        rst = 1'b0;
        repeat (50) @(negedge clk_sys);
        send_frame(8'h01, 8'h0C, 8'h0D, 8'h0E);
        drain();
        checks++;
        if (exp_q.size() != 0 || {dev_id, mod_id, cmd_addr, cmd_data} !== 32'h010C0D0E) begin $display("FAIL after_reset got=%h required=010c0d0e", {dev_id, mod_id, cmd_addr, cmd_data}); exp_q.delete(); end
        else passes++;
    endtask

    initial begin
        test_reset();
        test_valid();
        test_bcast_miss();
        test_bad_sum();
        test_framing();
        test_glitch();
        test_gap();
        test_back_to_back();
        test_reset_mid();
        repeat (10) @(negedge clk_sys);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
